// File: rtl/maze_pkg.sv
// Shared constants for the maze collision monitor: status encoding,
// the default cursor size and the visible screen limits.
package maze_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_HIT  = 2'b10;
  localparam logic [1:0] ST_WIN  = 2'b11;

  localparam int CURSOR_SIZE_DEF = 10;
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;

endpackage

// File: rtl/maze_collision_monitor_if.sv
// Pixel-stream, cursor, control and status bundle between the level
// graphics / game controller (master) and the collision monitor (slave).
interface maze_collision_monitor_if #(
  parameter int CNT_W = 8
);

  logic             enable;
  logic             clear;
  logic             refr_tick;
  logic             video_on;
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic             graph_on;
  logic             goal_on;
  logic [9:0]       cursor_x;
  logic [9:0]       cursor_y;
  logic             scare;
  logic             level_done;
  logic [1:0]       status;
  logic [CNT_W-1:0] wall_cnt;

  modport master (
    output enable, clear, refr_tick, video_on, pix_x, pix_y,
           graph_on, goal_on, cursor_x, cursor_y,
    input  scare, level_done, status, wall_cnt
  );

  modport slave (
    input  enable, clear, refr_tick, video_on, pix_x, pix_y,
           graph_on, goal_on, cursor_x, cursor_y,
    output scare, level_done, status, wall_cnt
  );

endinterface

// File: rtl/maze_overlap_counter.sv
// Saturating per-frame overlap accumulator. count_o already includes the
// sample presented this cycle, so frame-end decisions see the final pixel.
module maze_overlap_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_d;

endmodule

// File: rtl/maze_collision_monitor.sv
// Counts wall/goal pixels under the player square each frame and decides
// PLAY / HIT / WIN at frame end. Optional grace period: COLLISION_GRACE_EN.
module maze_collision_monitor
  import maze_pkg::*;
#(
  parameter int CURSOR_SIZE  = CURSOR_SIZE_DEF,
  parameter int HIT_THRESH   = 4,
  parameter int CNT_W        = 8,
  parameter int GRACE_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  maze_collision_monitor_if.slave  bus
);

  localparam logic [10:0]      SIZE11  = 11'(CURSOR_SIZE);
  localparam logic [10:0]      SCR_W11 = 11'(SCREEN_W);
  localparam logic [10:0]      SCR_H11 = 11'(SCREEN_H);
  localparam logic [CNT_W-1:0] HIT_TH  = CNT_W'(HIT_THRESH);

  logic [9:0]       cx_q, cy_q;
  logic [1:0]       state_q, state_d;
  logic             scare_q, level_done_q;
  logic [CNT_W-1:0] wall_cnt_q;
  logic [CNT_W-1:0] wall_acc, goal_acc;
  logic [10:0]      px, py, cx, cy;
  logic             in_window, qual, wall_inc, goal_inc;
  logic             held, acc_clr, hit_ok;

  // 11-bit compares so a cursor near 1023 cannot wrap its window
  assign px = {1'b0, bus.pix_x};
  assign py = {1'b0, bus.pix_y};
  assign cx = {1'b0, cx_q};
  assign cy = {1'b0, cy_q};

  assign in_window = (px >= cx) && (px < cx + SIZE11) &&
                     (py >= cy) && (py < cy + SIZE11);
  assign qual      = bus.video_on && in_window && (px < SCR_W11) && (py < SCR_H11);
  assign wall_inc  = qual && bus.graph_on && !bus.goal_on;
  assign goal_inc  = qual && bus.goal_on;

  assign held    = (state_q == ST_HIT) || (state_q == ST_WIN);
  assign acc_clr = bus.refr_tick || !bus.enable || (bus.clear && held);

  maze_overlap_counter #(.CNT_W(CNT_W)) u_wall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (wall_inc),
    .clr_i   (acc_clr),
    .count_o (wall_acc)
  );

  maze_overlap_counter #(.CNT_W(CNT_W)) u_goal_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (goal_inc),
    .clr_i   (acc_clr),
    .count_o (goal_acc)
  );

`ifdef COLLISION_GRACE_EN
  localparam int GW = $clog2(GRACE_FRAMES + 1);

  logic [GW-1:0] grace_q, grace_d;

  always_comb begin
    grace_d = grace_q;
    if ((state_d == ST_PLAY) && (state_q != ST_PLAY)) begin
      grace_d = GW'(GRACE_FRAMES);
    end else if (bus.refr_tick && (grace_q != '0)) begin
      grace_d = grace_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grace_q <= '0;
    end else begin
      grace_q <= grace_d;
    end
  end

  assign hit_ok = (grace_q == '0);
`else
  logic unused_grace;
  assign unused_grace = ^GRACE_FRAMES;
  assign hit_ok       = 1'b1;
`endif

  // Walls win over the goal when both were touched in the same frame
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.refr_tick) state_d = ST_PLAY;
        ST_PLAY: begin
          if (bus.refr_tick) begin
            if (hit_ok && (wall_acc >= HIT_TH)) begin
              state_d = ST_HIT;
            end else if (goal_acc != '0) begin
              state_d = ST_WIN;
            end
          end
        end
        default: if (bus.clear) state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      scare_q      <= 1'b0;
      level_done_q <= 1'b0;
      wall_cnt_q   <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      scare_q      <= (state_d == ST_HIT) && (state_q != ST_HIT);
      level_done_q <= (state_d == ST_WIN) && (state_q != ST_WIN);
      if (bus.refr_tick) begin
        wall_cnt_q <= wall_acc;
        cx_q       <= bus.cursor_x;
        cy_q       <= bus.cursor_y;
      end
    end
  end

  assign bus.scare      = scare_q;
  assign bus.level_done = level_done_q;
  assign bus.status     = state_q;
  assign bus.wall_cnt   = wall_cnt_q;

endmodule

// File: tb/tb_maze_collision_monitor.sv
// Directed bench for maze_collision_monitor: scans a small region around the
// latched cursor each frame, predicts frame-end results into a scoreboard.
module tb_maze_collision_monitor;

  localparam int CS      = 10;
  localparam int THRESH  = 4;
  localparam int GRACE_P = 2;

  typedef struct {
    logic [1:0] st;
    logic [7:0] wc;
    logic       sc;
    logic       ld;
    string      tag;
  } exp_t;

  logic clk;
  logic reset;

  maze_collision_monitor_if #(.CNT_W(8)) bus ();

  maze_collision_monitor #(
    .CURSOR_SIZE  (CS),
    .HIT_THRESH   (THRESH),
    .CNT_W        (8),
    .GRACE_FRAMES (GRACE_P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // reference model state
  logic [1:0] m_st    = 2'b00;
  int         m_wall  = 0;
  int         m_goal  = 0;
  int         m_wc    = 0;
  int         m_cx    = 0;
  int         m_cy    = 0;
  int         m_grace = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lvl_goal(input int x, input int y);
    return (x >= 140 && x <= 180 && y >= 400 && y <= 440);
  endfunction

  function automatic bit lvl_wall(input int x, input int y);
    bit border, top;
    border = (x <= 20) || (x >= 619) || (y <= 20) || (y >= 459);
    top    = (x >= 300 && x <= 580 && y >= 80 && y <= 120);
    return border || top || lvl_goal(x, y);
  endfunction

  // Scan a 14x12 patch around the latched cursor; custom mode lights the
  // first nw in-window pixels as wall and the next ng as goal.
  task automatic scan_frame(input bit use_lvl, input int nw, input int ng);
    int  k;
    bit  inw, g, go;
    k = 0;
    for (int y = m_cy - 1; y <= m_cy + CS; y++) begin
      for (int x = m_cx - 2; x <= m_cx + CS + 1; x++) begin
        if (x >= 0 && y >= 0) begin
          inw = (x >= m_cx) && (x < m_cx + CS) && (y >= m_cy) && (y < m_cy + CS);
          if (use_lvl) begin
            g  = lvl_wall(x, y);
            go = lvl_goal(x, y);
          end else begin
            g  = inw && (k < nw + ng);
            go = inw && (k >= nw) && (k < nw + ng);
          end
          if (inw) k++;
          bus.pix_x    = 10'(x);
          bus.pix_y    = 10'(y);
          bus.video_on = 1'b1;
          bus.graph_on = g;
          bus.goal_on  = go;
          if (inw && g && !go && m_wall < 255) m_wall++;
          if (inw && go && m_goal < 255) m_goal++;
          @(posedge clk);
          #1;
        end
      end
    end
    bus.video_on = 1'b0;
    bus.graph_on = 1'b0;
    bus.goal_on  = 1'b0;
  endtask

  // One control edge: predict, push, clock, pop and compare, then confirm
  // the event pulses drop after a single cycle.
  task automatic edge_step(input bit tick, input bit clr, input bit en, input string tag);
    exp_t       e;
    logic [1:0] prev, nxt;
    bus.refr_tick = tick;
    bus.clear     = clr;
    bus.enable    = en;
    prev = m_st;
    nxt  = prev;
    if (!en) nxt = 2'b00;
    else begin
      case (prev)
        2'b00: if (tick) nxt = 2'b01;
        2'b01: if (tick) begin
          if (m_wall >= THRESH && m_grace == 0) nxt = 2'b10;
          else if (m_goal >= 1)                 nxt = 2'b11;
        end
        default: if (clr) nxt = 2'b01;
      endcase
    end
`ifdef COLLISION_GRACE_EN
    if (nxt == 2'b01 && prev != 2'b01) m_grace = GRACE_P;
    else if (tick && m_grace > 0)      m_grace--;
`endif
    if (tick) begin
      m_wc = m_wall;
      m_cx = int'(bus.cursor_x);
      m_cy = int'(bus.cursor_y);
    end
    if (tick || !en || (clr && (prev == 2'b10 || prev == 2'b11))) begin
      m_wall = 0;
      m_goal = 0;
    end
    m_st  = nxt;
    e.st  = nxt;
    e.wc  = 8'(m_wc);
    e.sc  = (nxt == 2'b10) && (prev != 2'b10);
    e.ld  = (nxt == 2'b11) && (prev != 2'b11);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.refr_tick = 1'b0;
    bus.clear     = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    $display("step %-12s status=%0d wall_cnt=%0d scare=%0b level_done=%0b",
             e.tag, bus.status, bus.wall_cnt, bus.scare, bus.level_done);
    chk({e.tag, "_status"}, 32'(bus.status), 32'(e.st));
    chk({e.tag, "_wall_cnt"}, 32'(bus.wall_cnt), 32'(e.wc));
    chk({e.tag, "_scare"}, 32'(bus.scare), 32'(e.sc));
    chk({e.tag, "_level_done"}, 32'(bus.level_done), 32'(e.ld));
    @(negedge clk);
    chk({e.tag, "_scare_1cyc"}, 32'(bus.scare), 32'd0);
    chk({e.tag, "_done_1cyc"}, 32'(bus.level_done), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_status"}, 32'(bus.status), 32'd0);
    chk({tag, "_wall_cnt"}, 32'(bus.wall_cnt), 32'd0);
    chk({tag, "_scare"}, 32'(bus.scare), 32'd0);
    chk({tag, "_level_done"}, 32'(bus.level_done), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.clear     = 1'b0;
    bus.refr_tick = 1'b0;
    bus.video_on  = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.graph_on  = 1'b0;
    bus.goal_on   = 1'b0;
    bus.cursor_x  = 10'd200;
    bus.cursor_y  = 10'd250;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.enable = 1'b1;

    // arm: first tick only moves IDLE -> PLAY
    scan_frame(0, 6, 0);
    edge_step(1, 0, 1, "arm");
    for (int f = 0; f < 3; f++) begin
      scan_frame(1, 0, 0);
      edge_step(1, 0, 1, "free");
    end

    // top horizontal wall
    bus.cursor_x = 10'd400;
    bus.cursor_y = 10'd90;
    scan_frame(0, 0, 0);
    edge_step(1, 0, 1, "latch_wall");
    scan_frame(1, 0, 0);
    edge_step(1, 0, 1, "wall_hit");
    edge_step(0, 1, 1, "clear_hit");

    // goal box
    bus.cursor_x = 10'd150;
    bus.cursor_y = 10'd410;
    scan_frame(0, 0, 0);
    edge_step(1, 0, 1, "latch_goal");
    scan_frame(1, 0, 0);
    edge_step(1, 0, 1, "goal_win");
    edge_step(0, 1, 1, "clear_win");

    // threshold boundary and wall priority
    scan_frame(0, 3, 0);
    edge_step(1, 0, 1, "three_px");
    scan_frame(0, 4, 0);
    edge_step(1, 0, 1, "four_px");
    edge_step(0, 1, 1, "clear_4");
    scan_frame(0, 4, 1);
    edge_step(1, 0, 1, "wall_prio");

    // enable drop overrides clear and tick; re-enable on a tick arms at once
    edge_step(1, 1, 0, "disable");
    edge_step(1, 0, 1, "enable_tick");
    scan_frame(0, 2, 0);
    edge_step(1, 0, 1, "two_px");

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) begin
      bus.pix_x    = 10'(m_cx + i);
      bus.pix_y    = 10'(m_cy);
      bus.video_on = 1'b1;
      bus.graph_on = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #2;
    chk_zero("mid_reset");
    bus.video_on = 1'b0;
    bus.graph_on = 1'b0;
    m_st = 2'b00; m_wall = 0; m_goal = 0; m_wc = 0;
    m_cx = 0; m_cy = 0; m_grace = 0;
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.cursor_x = 10'd300;
    bus.cursor_y = 10'd200;

    // first frame after reset is not evaluated even with walls touched
    scan_frame(0, 8, 0);
    edge_step(1, 0, 1, "post_reset");
    for (int f = 0; f < 3; f++) begin
      scan_frame(0, 4, 0);
      edge_step(1, 0, 1, "grace_wall");
    end
    edge_step(0, 1, 1, "clear_grace");
    scan_frame(0, 0, 1);
    edge_step(1, 0, 1, "grace_goal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_collision_monitor.md
Name: maze_collision_monitor

Overview:
- Consumer of a maze level's wall/goal pixel stream (graph_on, goal_on) in the VGA scan path.
- Each frame, counts wall and goal pixels that fall inside the player cursor square, then decides at frame end: keep playing, collision (scare), or level complete.
- Sits between the level graphics generator and the game controller, which reads its one-cycle event pulses and status.

Parameters:
- CURSOR_SIZE, 10, side of the player square in pixels.
- HIT_THRESH, 4, minimum wall-overlap pixels in one frame to declare a collision.
- CNT_W, 8, width of the per-frame overlap counters (saturating).
- GRACE_FRAMES, 30, frames of collision immunity after arming (used only with the optional feature).

Ports:
- clk  in  1  pixel clock domain system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  game running for this level
- clear  in  1  acknowledge HIT/WIN and re-arm
- refr_tick  in  1  one-cycle pulse at start of vertical retrace (end of frame)
- video_on  in  1  active display region
- pix_x, pix_y  in  10 each  current scan pixel
- graph_on  in  1  current pixel is a wall (includes goal box)
- goal_on  in  1  current pixel is the goal box
- cursor_x, cursor_y  in  10 each  top-left of player square; sampled at refr_tick
- scare  out  1  one-cycle pulse on entering HIT
- level_done  out  1  one-cycle pulse on entering WIN
- status  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 WIN
- wall_cnt  out  CNT_W  wall-overlap count of the last completed frame

Behaviour:
- Reset (async, reset low): state IDLE; scare=0; level_done=0; status=00; wall_cnt=0; internal counters 0; cursor latch (0,0).
- Cursor latch: cursor_x/cursor_y are registered on refr_tick. In-window test uses latched values: cx<=pix_x<cx+CURSOR_SIZE and cy<=pix_y<cy+CURSOR_SIZE. Compute sums at 11 bits so no wrap near 1023.
- Sample qualifier: video_on && in_window.
- Pixel stage: inputs are used combinationally. Counters update on the next clk edge:
  - wall_acc increments when qualifier && graph_on && !goal_on.
  - goal_acc increments when qualifier && goal_on.
  - Both saturate at 2^CNT_W-1.
- Frame end: on refr_tick, wall_cnt <= wall_acc. The decision uses the final accumulator values (including a sample on the same cycle). Both accumulators reset to 0 on that same edge.
- FSM:
  - IDLE: if enable, wait for the next refr_tick, then go to PLAY. The first counted frame is therefore clean.
  - PLAY, on refr_tick: if wall_acc>=HIT_THRESH, go to HIT (wall priority even if goal also touched). Else if goal_acc>=1, go to WIN. Else stay.
  - HIT/WIN: hold. clear goes to PLAY, with accumulators zeroed.
  - Any state: enable=0 goes to IDLE next edge, overriding clear and refr_tick.
- scare/level_done are registered, asserted exactly one cycle on the edge the state enters HIT/WIN.
- refr_tick coincident with enable rising: go to PLAY immediately.
- Reset mid-frame discards partial counts.

Optional Feature:
- Macro COLLISION_GRACE_EN.
- Defined: a frame counter loads GRACE_FRAMES on every entry to PLAY and decrements on each refr_tick while nonzero. While it is nonzero, the HIT transition is suppressed; WIN is still allowed.
- Undefined: no counter; HIT is evaluated from the first PLAY frame.

Decomposition:
- Shared package maze_pkg: status encoding localparams (ST_IDLE, ST_PLAY, ST_HIT, ST_WIN), CURSOR_SIZE default, screen limits 640x480.
- One sub-module, maze_overlap_counter: a saturating CNT_W counter with inc, clear-on-tick, and a count output. Instantiated twice (wall, goal).

Test Plan:
- Enable, then cursor (200,250) in free space with the real level walls for 3 frames -> status=01, no pulses, wall_cnt=0.
- Cursor (400,90) inside top horizontal wall (x300..580, y80..120) -> after one full frame wall_cnt=100; scare pulses 1 cycle on the refr_tick edge; status=10; clear -> 01.
- Cursor (150,410) inside goal box (x140..180, y400..440) -> level_done pulse; status=11; wall_cnt=0 (goal pixels excluded).
- Bench drives graph_on high for exactly 3 in-window pixels -> stays PLAY; repeat with 4 -> HIT. Repeat with 4 wall pixels plus 1 goal pixel in the same frame -> HIT, not WIN.
- Drop enable while in HIT with clear and refr_tick asserted the same cycle -> IDLE. Pulse reset low mid-frame -> all outputs 0 asynchronously; after release, the first frame is not evaluated.
- With COLLISION_GRACE_EN and GRACE_FRAMES=2 -> wall overlap in frames 1–2 is ignored; frame 3 gives HIT. Goal overlap in frame 1 still gives WIN.
